// File: rtl/int_issue_queue_pkg.sv
// rtl/int_issue_queue_pkg.sv - shared uop type, widths and ROB-index kill rule for the integer issue path
package int_isq_pkg;

    localparam int ISQ_DEPTH = 8;
    localparam int PREG_W    = 6;
    localparam int XLEN      = 64;
    localparam int ROB_W     = 4;

    typedef struct packed {
        logic [PREG_W-1:0] prd;
        logic [PREG_W-1:0] prs1;
        logic [PREG_W-1:0] prs2;
        logic [XLEN-1:0]   src1;
        logic [XLEN-1:0]   src2;
        logic              src1_rdy;
        logic              src2_rdy;
        logic [31:0]       imm;
        logic              need_to_wb;
        logic [2:0]        cx_type;
        logic              is_unsigned;
        logic [3:0]        alu_type;
        logic              is_word;
        logic              is_imm;
        logic [2:0]        muldiv_type;
        logic [31:0]       pc;
        logic              robidx_flag;
        logic [ROB_W-1:0]  robidx;
    } isq_uop_t;

    // True when uop x is younger than the flushing instruction; the flusher itself survives
    function automatic logic rob_kill(
        input logic             flush_valid,
        input logic             flush_flag,
        input logic [ROB_W-1:0] flush_idx,
        input logic             x_flag,
        input logic [ROB_W-1:0] x_idx
    );
        return flush_valid & ((flush_flag ^ x_flag) ^ (flush_idx < x_idx));
    endfunction

endpackage

// File: rtl/int_issue_queue_if.sv
// rtl/int_issue_queue_if.sv - issue handshake from the queue (master) to the integer execution block (slave)
interface int_issue_queue_if;
    import int_isq_pkg::*;

    logic     instr_valid;
    logic     instr_ready;
    isq_uop_t issue_uop;

    modport master (output instr_valid, output issue_uop, input instr_ready);
    modport slave  (input instr_valid, input issue_uop, output instr_ready);
endinterface

// File: rtl/int_issue_queue_select.sv
// rtl/int_issue_queue_select.sv - lowest-index-first priority encoder with one-hot grant and index
module isq_select #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    // Scan from the top so the lowest requesting index wins
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = IW'(i);
                o_any = 1'b1;
            end
        end
    end

    assign o_grant = o_any ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/int_issue_queue.sv
// rtl/int_issue_queue.sv - compacting integer issue queue with oldest-ready select; ISQ_BYPASS_EN enables same-cycle wakeup select
module int_issue_queue
    import int_isq_pkg::*;
#(
    parameter int DEPTH = ISQ_DEPTH
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              enq_valid,
    output logic                              enq_ready,
    input  isq_uop_t                          enq_uop,
    input  logic                              wb_valid,
    input  logic [PREG_W-1:0]                 wb_prd,
    input  logic [XLEN-1:0]                   wb_result,
    int_issue_queue_if.master                 iss,
    input  logic                              flush_valid,
    input  logic                              flush_robidx_flag,
    input  logic [ROB_W-1:0]                  flush_robidx,
    output logic [$clog2(DEPTH):0]            count
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    isq_uop_t          r_ent [DEPTH];
    logic [DEPTH-1:0]  r_vld;
    logic [CW-1:0]     r_count;
    logic              r_iss_vld;
    isq_uop_t          r_iss_uop;

    isq_uop_t          w_wk_ent  [DEPTH];
    isq_uop_t          w_nxt_ent [DEPTH];
    isq_uop_t          w_enq_wk;
    logic [DEPTH-1:0]  w_kill;
    logic [DEPTH-1:0]  w_rdy;
    logic [DEPTH-1:0]  w_stay;
    logic [DEPTH-1:0]  w_nxt_vld;
    logic [DEPTH-1:0]  w_grant;
    logic [IW-1:0]     w_sel_idx;
    logic              w_sel_any;
    logic              w_can_sel;
    logic              w_sel_fire;
    logic              w_iss_kill;
    logic              w_enq_ready;
    logic              w_enq_fire;
    logic [CW-1:0]     w_pos;
    logic [CW-1:0]     w_nxt_count;

    // Capture broadcast data into any pending source that matches the written register
    function automatic isq_uop_t wake(
        input isq_uop_t          u,
        input logic              v,
        input logic [PREG_W-1:0] prd,
        input logic [XLEN-1:0]   res
    );
        isq_uop_t o;
        o = u;
        if (v && !o.src1_rdy && (o.prs1 == prd)) begin
            o.src1     = res;
            o.src1_rdy = 1'b1;
        end
        if (v && !o.src2_rdy && (o.prs2 == prd)) begin
            o.src2     = res;
            o.src2_rdy = 1'b1;
        end
        return o;
    endfunction

    // Per-entry wakeup, flush kill and select request
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_wk_ent[i] = wake(r_ent[i], wb_valid, wb_prd, wb_result);
            w_kill[i]   = r_vld[i] & rob_kill(flush_valid, flush_robidx_flag, flush_robidx,
                                              r_ent[i].robidx_flag, r_ent[i].robidx);
`ifdef ISQ_BYPASS_EN
            w_rdy[i]    = r_vld[i] & ~w_kill[i] & w_wk_ent[i].src1_rdy & w_wk_ent[i].src2_rdy;
`else
            w_rdy[i]    = r_vld[i] & ~w_kill[i] & r_ent[i].src1_rdy & r_ent[i].src2_rdy;
`endif
        end
    end

    assign w_enq_wk    = wake(enq_uop, wb_valid, wb_prd, wb_result);
    assign w_iss_kill  = r_iss_vld & rob_kill(flush_valid, flush_robidx_flag, flush_robidx,
                                              r_iss_uop.robidx_flag, r_iss_uop.robidx);
    // A killed issue-register uop frees the slot so a survivor can take it the same cycle
    assign w_can_sel   = ~r_iss_vld | iss.instr_ready | w_iss_kill;
    assign w_sel_fire  = w_can_sel & w_sel_any;
    assign w_enq_ready = (r_count < CW'(DEPTH));
    assign w_enq_fire  = enq_valid & w_enq_ready &
                         ~rob_kill(flush_valid, flush_robidx_flag, flush_robidx,
                                   enq_uop.robidx_flag, enq_uop.robidx);

    isq_select #(.N(DEPTH)) u_select (
        .i_req   (w_rdy),
        .o_grant (w_grant),
        .o_idx   (w_sel_idx),
        .o_any   (w_sel_any)
    );

    // Re-compact survivors toward index 0 and append the enqueuing uop behind them
    always_comb begin
        w_pos = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_nxt_ent[i] = '0;
            w_nxt_vld[i] = 1'b0;
            w_stay[i]    = r_vld[i] & ~w_kill[i] & ~(w_sel_fire & w_grant[i]);
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (w_stay[i]) begin
                w_nxt_ent[w_pos[IW-1:0]] = w_wk_ent[i];
                w_nxt_vld[w_pos[IW-1:0]] = 1'b1;
                w_pos = w_pos + CW'(1);
            end
        end
        w_nxt_count = w_pos;
        if (w_enq_fire) begin
            w_nxt_ent[w_pos[IW-1:0]] = w_enq_wk;
            w_nxt_vld[w_pos[IW-1:0]] = 1'b1;
            w_nxt_count = w_pos + CW'(1);
        end
    end

    // Queue storage and occupancy
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= '0;
            end
            r_vld   <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= w_nxt_ent[i];
            end
            r_vld   <= w_nxt_vld;
            r_count <= w_nxt_count;
        end
    end

    // Issue register: load on select, drop on accept or kill, otherwise hold
    always_ff @(posedge clock) begin
        if (reset) begin
            r_iss_vld <= 1'b0;
            r_iss_uop <= '0;
        end else if (w_sel_fire) begin
            r_iss_vld <= 1'b1;
            r_iss_uop <= w_wk_ent[w_sel_idx];
        end else if (w_iss_kill | iss.instr_ready) begin
            r_iss_vld <= 1'b0;
        end
    end

    assign enq_ready       = w_enq_ready;
    assign count           = r_count;
    assign iss.instr_valid = r_iss_vld;
    assign iss.issue_uop   = r_iss_uop;

endmodule

// File: tb/tb_int_issue_queue.sv
// tb/tb_int_issue_queue.sv - directed self-checking bench for int_issue_queue
module tb_int_issue_queue;
    import int_isq_pkg::*;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              enq_valid = 1'b0;
    logic              enq_ready;
    isq_uop_t          enq_uop = '0;
    logic              wb_valid = 1'b0;
    logic [PREG_W-1:0] wb_prd = '0;
    logic [XLEN-1:0]   wb_result = '0;
    logic              flush_valid = 1'b0;
    logic              flush_robidx_flag = 1'b0;
    logic [ROB_W-1:0]  flush_robidx = '0;
    logic [3:0]        count;

    int n_total = 0;
    int n_bad   = 0;

    int_issue_queue_if iss_if ();

    int_issue_queue #(.DEPTH(8)) dut (
        .clock             (clock),
        .reset             (reset),
        .enq_valid         (enq_valid),
        .enq_ready         (enq_ready),
        .enq_uop           (enq_uop),
        .wb_valid          (wb_valid),
        .wb_prd            (wb_prd),
        .wb_result         (wb_result),
        .iss               (iss_if.master),
        .flush_valid       (flush_valid),
        .flush_robidx_flag (flush_robidx_flag),
        .flush_robidx      (flush_robidx),
        .count             (count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic isq_uop_t mk(input int rob, input logic flag, input logic r1, input int p1);
        isq_uop_t u;
        u             = '0;
        u.robidx      = ROB_W'(rob);
        u.robidx_flag = flag;
        u.src1_rdy    = r1;
        u.src2_rdy    = 1'b1;
        u.prs1        = PREG_W'(p1);
        u.prd         = PREG_W'(rob + 16);
        u.pc          = 32'(rob * 4);
        u.src1        = r1 ? XLEN'(rob * 100) : '0;
        return u;
    endfunction

    initial begin
        iss_if.instr_ready = 1'b0;
        tick();
        tick();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_enq_ready", 64'(enq_ready), 64'd1);
        chk("rst_vld", 64'(iss_if.instr_valid), 64'd0);
        chk("rst_uop_zero", 64'(iss_if.issue_uop == '0), 64'd1);
        reset = 1'b0;
        tick();

        // three ready uops, issued in order starting two cycles after the first enqueue
        iss_if.instr_ready = 1'b1;
        enq_valid = 1'b1;
        enq_uop   = mk(1, 1'b0, 1'b1, 0);
        tick();
        chk("t1_n1_vld", 64'(iss_if.instr_valid), 64'd0);
        enq_uop = mk(2, 1'b0, 1'b1, 0);
        tick();
        chk("t1_n2_vld", 64'(iss_if.instr_valid), 64'd1);
        chk("t1_n2_rob", 64'(iss_if.issue_uop.robidx), 64'd1);
        enq_uop = mk(3, 1'b0, 1'b1, 0);
        tick();
        chk("t1_n3_rob", 64'(iss_if.issue_uop.robidx), 64'd2);
        enq_valid = 1'b0;
        tick();
        chk("t1_n4_rob", 64'(iss_if.issue_uop.robidx), 64'd3);
        tick();
        chk("t1_n5_vld", 64'(iss_if.instr_valid), 64'd0);

        // wakeup of a pending source
        enq_valid = 1'b1;
        enq_uop   = mk(4, 1'b0, 1'b0, 5);
        tick();
        enq_valid = 1'b0;
        tick();
        chk("t2_wait_vld", 64'(iss_if.instr_valid), 64'd0);
        wb_valid  = 1'b1;
        wb_prd    = 6'd5;
        wb_result = 64'h1234;
        tick();
        wb_valid = 1'b0;
`ifdef ISQ_BYPASS_EN
        chk("t2_m1_vld", 64'(iss_if.instr_valid), 64'd1);
`else
        chk("t2_m1_vld", 64'(iss_if.instr_valid), 64'd0);
        tick();
        chk("t2_m2_vld", 64'(iss_if.instr_valid), 64'd1);
`endif
        chk("t2_src1", iss_if.issue_uop.src1, 64'h1234);
        chk("t2_rob", 64'(iss_if.issue_uop.robidx), 64'd4);
        tick();
        chk("t2_done_vld", 64'(iss_if.instr_valid), 64'd0);

        // back-pressure: first uop parks in the issue register, 8 fill the queue, 10th refused
        iss_if.instr_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            enq_valid = 1'b1;
            enq_uop   = mk(k + 1, 1'b0, 1'b1, 0);
            chk($sformatf("t3_enq_ready%0d", k), 64'(enq_ready), 64'(k < 9));
            tick();
        end
        enq_valid = 1'b0;
        chk("t3_full_count", 64'(count), 64'd8);
        chk("t3_full_rdy", 64'(enq_ready), 64'd0);
        chk("t3_hold_vld", 64'(iss_if.instr_valid), 64'd1);
        chk("t3_hold_rob", 64'(iss_if.issue_uop.robidx), 64'd1);
        tick();
        chk("t3_hold_rob2", 64'(iss_if.issue_uop.robidx), 64'd1);
        iss_if.instr_ready = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            chk($sformatf("t3_drain_vld%0d", k), 64'(iss_if.instr_valid), 64'd1);
            chk($sformatf("t3_drain_rob%0d", k), 64'(iss_if.issue_uop.robidx), 64'(k));
            tick();
        end
        chk("t3_empty_vld", 64'(iss_if.instr_valid), 64'd0);
        chk("t3_empty_count", 64'(count), 64'd0);

        // flush at robidx 3 removes 4 and 5
        iss_if.instr_ready = 1'b0;
        for (int r = 2; r <= 5; r++) begin
            enq_valid = 1'b1;
            enq_uop   = mk(r, 1'b0, 1'b0, 9);
            tick();
        end
        enq_valid = 1'b0;
        chk("t4_pre_count", 64'(count), 64'd4);
        flush_valid       = 1'b1;
        flush_robidx      = 4'd3;
        flush_robidx_flag = 1'b0;
        tick();
        flush_valid = 1'b0;
        chk("t4_post_count", 64'(count), 64'd2);
        wb_valid  = 1'b1;
        wb_prd    = 6'd9;
        wb_result = 64'h55;
        iss_if.instr_ready = 1'b1;
        tick();
        wb_valid = 1'b0;
        for (int w = 0; w < 4 && !iss_if.instr_valid; w++) tick();
        chk("t4_first_vld", 64'(iss_if.instr_valid), 64'd1);
        chk("t4_first_rob", 64'(iss_if.issue_uop.robidx), 64'd2);
        chk("t4_first_src1", iss_if.issue_uop.src1, 64'h55);
        tick();
        chk("t4_second_vld", 64'(iss_if.instr_valid), 64'd1);
        chk("t4_second_rob", 64'(iss_if.issue_uop.robidx), 64'd3);
        tick();
        chk("t4_end_vld", 64'(iss_if.instr_valid), 64'd0);
        chk("t4_end_count", 64'(count), 64'd0);

        // flag wrap: issue-register uop (rob 1, flag 1) killed by flush (rob 6, flag 0); rob 5 flag 0 replaces it
        iss_if.instr_ready = 1'b0;
        enq_valid = 1'b1;
        enq_uop   = mk(1, 1'b1, 1'b1, 0);
        tick();
        enq_uop = mk(5, 1'b0, 1'b1, 0);
        tick();
        enq_valid = 1'b0;
        tick();
        chk("t5_pre_rob", 64'(iss_if.issue_uop.robidx), 64'd1);
        chk("t5_pre_flag", 64'(iss_if.issue_uop.robidx_flag), 64'd1);
        flush_valid       = 1'b1;
        flush_robidx      = 4'd6;
        flush_robidx_flag = 1'b0;
        tick();
        flush_valid = 1'b0;
        chk("t5_post_vld", 64'(iss_if.instr_valid), 64'd1);
        chk("t5_post_rob", 64'(iss_if.issue_uop.robidx), 64'd5);
        chk("t5_post_count", 64'(count), 64'd0);
        iss_if.instr_ready = 1'b1;
        tick();
        chk("t5_end_vld", 64'(iss_if.instr_valid), 64'd0);

        // enqueue + wakeup + flush in one cycle: younger enqueue dropped, older entry woken
        iss_if.instr_ready = 1'b0;
        enq_valid = 1'b1;
        enq_uop   = mk(1, 1'b0, 1'b1, 0);
        tick();
        enq_uop = mk(2, 1'b0, 1'b0, 11);
        tick();
        enq_valid = 1'b0;
        tick();
        chk("t6_pre_count", 64'(count), 64'd1);
        enq_valid         = 1'b1;
        enq_uop           = mk(4, 1'b0, 1'b0, 11);
        wb_valid          = 1'b1;
        wb_prd            = 6'd11;
        wb_result         = 64'habc;
        flush_valid       = 1'b1;
        flush_robidx      = 4'd3;
        flush_robidx_flag = 1'b0;
        tick();
        enq_valid   = 1'b0;
        wb_valid    = 1'b0;
        flush_valid = 1'b0;
        chk("t6_post_count", 64'(count), 64'd1);
        chk("t6_iss_rob", 64'(iss_if.issue_uop.robidx), 64'd1);
        iss_if.instr_ready = 1'b1;
        tick();
        chk("t6_next_vld", 64'(iss_if.instr_valid), 64'd1);
        chk("t6_next_rob", 64'(iss_if.issue_uop.robidx), 64'd2);
        chk("t6_next_src1", iss_if.issue_uop.src1, 64'habc);
        tick();
        chk("t6_end_vld", 64'(iss_if.instr_valid), 64'd0);
        chk("t6_end_count", 64'(count), 64'd0);

        // reset mid-operation drops the handshake and empties the queue
        iss_if.instr_ready = 1'b0;
        enq_valid = 1'b1;
        enq_uop   = mk(3, 1'b0, 1'b1, 0);
        tick();
        enq_uop = mk(4, 1'b0, 1'b1, 0);
        tick();
        enq_valid = 1'b0;
        chk("t7_pre_vld", 64'(iss_if.instr_valid), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t7_vld", 64'(iss_if.instr_valid), 64'd0);
        chk("t7_count", 64'(count), 64'd0);
        chk("t7_uop_zero", 64'(iss_if.issue_uop == '0), 64'd1);
        chk("t7_enq_ready", 64'(enq_ready), 64'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
